// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and counter sizing helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width for a WIDTH-bit serial operation.
    function automatic int CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fsub.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module fsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation/propagation.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH bits,
// one bit per clock, under a start/busy/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    // The minuend register doubles as the result shift register: each
    // difference bit enters at the MSB as the consumed minuend bit leaves
    // the LSB, so after WIDTH shifts it holds the full result.
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             zero_reg;

    logic             bit_d;
    logic             bit_br;
    logic [WIDTH-1:0] a_sh_next;
    logic             accept;
    logic             last_bit;

    fsub u_fsub (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .d    (bit_d),
        .bout (bit_br)
    );

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign a_sh_next = bit_d;
        end else begin : g_shift_wn
            assign a_sh_next = {bit_d, a_sh_reg[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = start && (state_reg != RUN);
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE can go straight back to RUN on a new start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-bit shifting, and result latch on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            borrow_reg <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
        end else if (accept) begin
            cnt_reg    <= '0;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
        end else if (state_reg == RUN) begin
            cnt_reg    <= cnt_reg + CW'(1);
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_reg >> 1;
            borrow_reg <= bit_br;
            if (last_bit) begin
                diff_reg <= a_sh_next;
                bout_reg <= bit_br;
                zero_reg <= (a_sh_next == '0);
            end
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;

endmodule
